// File: rtl/ex_stage_mc.sv
// Execute stage with EX/M pipeline register, operand forwarding, synchronous flush
// and a multi-cycle shift-add multiplier that stalls the front end while it runs.
module ex_stage_mc #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int ZERO_HARD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] rs_content,
    input  logic [DATA_W-1:0] rt_content,
    input  logic [DATA_W-1:0] immediate,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    input  logic [2:0]        ALUop,
    input  logic              ALUsrc,
    input  logic              dst,
    input  logic              memread,
    input  logic              memwrite,
    input  logic              memtoreg,
    input  logic              regwrite,
    input  logic [REG_AW-1:0] M_WB_rd,
    input  logic [DATA_W-1:0] M_WB_data,
    input  logic              M_WB_regwrite,
    output logic              ex_busy,
    output logic [DATA_W-1:0] EX_M_result,
    output logic [DATA_W-1:0] EX_M_write_data,
    output logic [REG_AW-1:0] EX_M_rd,
    output logic              EX_M_memread,
    output logic              EX_M_memwrite,
    output logic              EX_M_memtoreg,
    output logic              EX_M_regwrite
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [2:0] {
        OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
        OP_SLT = 3'd4, OP_MUL = 3'd5, OP_XOR = 3'd6, OP_NOR = 3'd7
    } alu_op_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  acc;
    logic [DATA_W-1:0]  m_a;
    logic [DATA_W-1:0]  m_b;
    logic [DATA_W-1:0]  m_wd;
    logic [REG_AW-1:0]  m_rd;
    logic [3:0]         m_ctrl;
    logic [3:0]         ex_m_ctrl;

    logic [DATA_W-1:0]  fwd_a;
    logic [DATA_W-1:0]  fwd_b;
    logic [DATA_W-1:0]  op_b;
    logic [DATA_W-1:0]  alu;
    logic [REG_AW-1:0]  rd2;
    logic [3:0]         ctrl_in;
    logic               rs_zero;
    logic               rt_zero;
    logic               mul_issue;

    assign rs_zero = (ZERO_HARD != 0) && (rs == '0);
    assign rt_zero = (ZERO_HARD != 0) && (rt == '0);
    assign rd2     = dst ? rd : rt;
    assign ctrl_in = {memread, memwrite, memtoreg, regwrite};

    assign {EX_M_memread, EX_M_memwrite, EX_M_memtoreg, EX_M_regwrite} = ex_m_ctrl;

    // EX/M takes priority over M/WB because it holds the younger write
    always_comb begin
        fwd_a = rs_content;
        if (!rs_zero && EX_M_regwrite && EX_M_rd == rs)
            fwd_a = EX_M_result;
        else if (!rs_zero && M_WB_regwrite && M_WB_rd == rs)
            fwd_a = M_WB_data;

        fwd_b = rt_content;
        if (!rt_zero && EX_M_regwrite && EX_M_rd == rt)
            fwd_b = EX_M_result;
        else if (!rt_zero && M_WB_regwrite && M_WB_rd == rt)
            fwd_b = M_WB_data;

        op_b = ALUsrc ? immediate : fwd_b;
    end

    always_comb begin
        alu = '0;
        case (alu_op_t'(ALUop))
            OP_ADD:  alu = fwd_a + op_b;
            OP_SUB:  alu = fwd_a - op_b;
            OP_AND:  alu = fwd_a & op_b;
            OP_OR:   alu = fwd_a | op_b;
            OP_SLT:  alu = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
            OP_XOR:  alu = fwd_a ^ op_b;
            OP_NOR:  alu = ~(fwd_a | op_b);
            default: alu = '0;
        endcase
    end

    assign mul_issue = id_valid && (alu_op_t'(ALUop) == OP_MUL) && !flush;

    // Gated by rst so a mul waiting on the inputs cannot raise the stall during reset
    always_comb begin
        ex_busy = 1'b0;
        if (rst) begin
            case (state)
                IDLE:    ex_busy = mul_issue;
                BUSY:    ex_busy = !flush;
                default: ex_busy = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            cnt             <= '0;
            acc             <= '0;
            m_a             <= '0;
            m_b             <= '0;
            m_wd            <= '0;
            m_rd            <= '0;
            m_ctrl          <= '0;
            EX_M_result     <= '0;
            EX_M_write_data <= '0;
            EX_M_rd         <= '0;
            ex_m_ctrl       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_issue) begin
                        // operands are captured now: forwarding sources drain during the stall
                        m_a       <= fwd_a;
                        m_b       <= op_b;
                        m_wd      <= fwd_b;
                        m_rd      <= rd2;
                        m_ctrl    <= ctrl_in;
                        acc       <= '0;
                        cnt       <= '0;
                        ex_m_ctrl <= '0;
                        state     <= BUSY;
                    end else begin
                        EX_M_result     <= alu;
                        EX_M_write_data <= fwd_b;
                        EX_M_rd         <= rd2;
                        ex_m_ctrl       <= (id_valid && !flush) ? ctrl_in : '0;
                    end
                end
                BUSY: begin
                    ex_m_ctrl <= '0;
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        if (m_b[cnt])
                            acc <= acc + (m_a << cnt);
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(DATA_W - 1))
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (flush) begin
                        ex_m_ctrl <= '0;
                    end else begin
                        EX_M_result     <= acc;
                        EX_M_write_data <= m_wd;
                        EX_M_rd         <= m_rd;
                        ex_m_ctrl       <= m_ctrl;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
